// File: rtl/aq_rtu_fflags_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : aq_rtu_fflags_buf_if
// Description : Signal bundle between the IDU, the FPU writeback path, the
//               retire logic and the in-order FP exception-flag buffer.
//               master : the pipeline side that drives allocate, writeback,
//                        retire and flush requests
//               slave  : the flag buffer itself
// Ports       : idu_rtu_fp_alloc, rtu_idu_fp_alloc_ptr, rtu_idu_fp_full,
//               vfpu_rtu_wb_vld/ptr/fflags, rtu_fp_head_done, rtu_retire_fp,
//               rtu_flush, rtu_cp0_fflags, rtu_cp0_fflags_updt,
//               fs_dirty_upd_gate
// Revision    : 1.0 - initial release
// ============================================================================
interface aq_rtu_fflags_buf_if #(
    parameter int PTR_W = 2
);
    logic             idu_rtu_fp_alloc;
    logic [PTR_W-1:0] rtu_idu_fp_alloc_ptr;
    logic             rtu_idu_fp_full;
    logic             vfpu_rtu_wb_vld;
    logic [PTR_W-1:0] vfpu_rtu_wb_ptr;
    logic [4:0]       vfpu_rtu_wb_fflags;
    logic             rtu_fp_head_done;
    logic             rtu_retire_fp;
    logic             rtu_flush;
    logic [4:0]       rtu_cp0_fflags;
    logic             rtu_cp0_fflags_updt;
    logic             fs_dirty_upd_gate;

    modport master (
        output idu_rtu_fp_alloc,
        input  rtu_idu_fp_alloc_ptr,
        input  rtu_idu_fp_full,
        output vfpu_rtu_wb_vld,
        output vfpu_rtu_wb_ptr,
        output vfpu_rtu_wb_fflags,
        input  rtu_fp_head_done,
        output rtu_retire_fp,
        output rtu_flush,
        input  rtu_cp0_fflags,
        input  rtu_cp0_fflags_updt,
        input  fs_dirty_upd_gate
    );

    modport slave (
        input  idu_rtu_fp_alloc,
        output rtu_idu_fp_alloc_ptr,
        output rtu_idu_fp_full,
        input  vfpu_rtu_wb_vld,
        input  vfpu_rtu_wb_ptr,
        input  vfpu_rtu_wb_fflags,
        output rtu_fp_head_done,
        input  rtu_retire_fp,
        input  rtu_flush,
        output rtu_cp0_fflags,
        output rtu_cp0_fflags_updt,
        output fs_dirty_upd_gate
    );
endinterface
`default_nettype wire

// File: rtl/aq_rtu_fflags_buf.sv
`default_nettype none
// ============================================================================
// Module      : aq_rtu_fflags_buf
// Description : In-order buffer of FP exception flags sitting between FPU
//               writeback and the float CSR. Each FP instruction takes an
//               entry at dispatch, the entry captures its fflags at
//               writeback, and the oldest entry drains at retire so the CSR
//               only accumulates flags of committed instructions. Flushed
//               entries are discarded and never reach the CSR.
// Ports       : forever_cpuclk - clock
//               cpurst         - asynchronous reset, active-high
//               bus (slave)    - alloc / writeback / retire / flush requests
//                                and alloc tag, full, head-done, CSR update
//                                and FS-dirty pulses
// Options     : AQ_FFLAGS_WB_BYPASS_EN - when defined, a writeback to the
//               head entry makes it retirable in the same cycle and its
//               flags are forwarded straight to the CSR update.
// Revision    : 1.0 - initial release
// ============================================================================
module aq_rtu_fflags_buf #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  wire logic          forever_cpuclk,
    input  wire logic          cpurst,
    aq_rtu_fflags_buf_if.slave bus
);

    localparam logic [PTR_W:0] c_DEPTH_CNT = (PTR_W+1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_done;
    logic [4:0]       r_flags [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    logic [4:0]       r_cp0_fflags;
    logic             r_updt;
    logic             r_gate;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    logic             w_full;
    logic             w_alloc;
    logic             w_wb_hit;
    logic             w_head_rdy;
    logic             w_head_done;
    logic             w_retire;
    logic [4:0]       w_ret_flags;
    logic [PTR_W:0]   w_count_nxt;

    assign w_full     = (r_count == c_DEPTH_CNT);
    // Full is judged on the registered count, so a same-cycle retire does
    // not open a slot for a same-cycle allocate.
    assign w_alloc    = bus.idu_rtu_fp_alloc & ~w_full & ~bus.rtu_flush;
    assign w_wb_hit   = bus.vfpu_rtu_wb_vld & r_vld[bus.vfpu_rtu_wb_ptr];
    assign w_head_rdy = r_vld[r_head] & r_done[r_head];

`ifdef AQ_FFLAGS_WB_BYPASS_EN
    logic w_wb_head;
    // Writeback landing on the head this cycle makes it retirable now;
    // the fresh flags win over whatever the entry held before.
    assign w_wb_head   = bus.vfpu_rtu_wb_vld & r_vld[r_head] &
                         (bus.vfpu_rtu_wb_ptr == r_head);
    assign w_head_done = w_head_rdy | w_wb_head;
    assign w_ret_flags = w_wb_head ? bus.vfpu_rtu_wb_fflags : r_flags[r_head];
`else
    assign w_head_done = w_head_rdy;
    assign w_ret_flags = r_flags[r_head];
`endif

    assign w_retire = bus.rtu_retire_fp & w_head_done;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_alloc, w_retire})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // ------------------------------------------------------------------
    // Entry array and pointers
    // ------------------------------------------------------------------
    // Alloc targets the tail (never valid when accepted) and retire the
    // head (never equal to the tail when an alloc is accepted alongside a
    // non-empty buffer), so per-entry updates below never collide.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_vld   <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_flags[i] <= '0;
            end
        end else if (bus.rtu_flush) begin
            // Flush discards everything pending, including same-cycle
            // alloc and writeback; a same-cycle retire still pulses via
            // the output register below.
            r_vld   <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc && (r_tail == PTR_W'(i))) begin
                    r_vld[i]   <= 1'b1;
                    r_done[i]  <= 1'b0;
                    r_flags[i] <= '0;
                end
                if (w_wb_hit && (bus.vfpu_rtu_wb_ptr == PTR_W'(i))) begin
                    r_done[i]  <= 1'b1;
                    r_flags[i] <= bus.vfpu_rtu_wb_fflags;
                end
                if (w_retire && (r_head == PTR_W'(i))) begin
                    r_vld[i]  <= 1'b0;
                    r_done[i] <= 1'b0;
                end
            end
            if (w_alloc) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_retire) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // CSR update and FS-dirty pulses, one cycle after an accepted retire
    // ------------------------------------------------------------------
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_cp0_fflags <= '0;
            r_updt       <= 1'b0;
            r_gate       <= 1'b0;
        end else begin
            r_updt <= w_retire;
            r_gate <= w_retire;
            // Flags hold their last retired value between pulses.
            if (w_retire) begin
                r_cp0_fflags <= w_ret_flags;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rtu_idu_fp_alloc_ptr = r_tail;
    assign bus.rtu_idu_fp_full      = w_full;
    assign bus.rtu_fp_head_done     = w_head_done;
    assign bus.rtu_cp0_fflags       = r_cp0_fflags;
    assign bus.rtu_cp0_fflags_updt  = r_updt;
    assign bus.fs_dirty_upd_gate    = r_gate;

endmodule
`default_nettype wire

// File: tb/tb_aq_rtu_fflags_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_aq_rtu_fflags_buf
// Description : Self-checking bench for aq_rtu_fflags_buf. A queue-based
//               reference model of in-flight FP instructions (ordered tags
//               with per-tag done/flags) predicts every output. Directed
//               scenarios are followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aq_rtu_fflags_buf;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
`ifdef AQ_FFLAGS_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;

    aq_rtu_fflags_buf_if #(.PTR_W(PTR_W)) bus ();

    aq_rtu_fflags_buf #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .bus            (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model: in-order list of live tags plus per-tag state.
    int         m_q [$];
    bit         m_done  [DEPTH];
    logic [4:0] m_flags [DEPTH];
    int         m_tail;
    logic [4:0] m_ff;
    bit         m_updt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_q(input int t);
        foreach (m_q[k]) if (m_q[k] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            m_done[i]  = 1'b0;
            m_flags[i] = 5'd0;
        end
        m_tail = 0;
        m_ff   = 5'd0;
        m_updt = 1'b0;
    endtask

    task automatic drive(input bit a, input bit wv, input logic [1:0] wp,
                         input logic [4:0] wf, input bit r, input bit f);
        bus.idu_rtu_fp_alloc   = a;
        bus.vfpu_rtu_wb_vld    = wv;
        bus.vfpu_rtu_wb_ptr    = wp;
        bus.vfpu_rtu_wb_fflags = wf;
        bus.rtu_retire_fp      = r;
        bus.rtu_flush          = f;
    endtask

    task automatic chk_regs();
        chk("full",      32'(bus.rtu_idu_fp_full),      32'(m_q.size() == DEPTH));
        chk("alloc_ptr", 32'(bus.rtu_idu_fp_alloc_ptr), 32'(m_tail));
        chk("updt",      32'(bus.rtu_cp0_fflags_updt),  32'(m_updt));
        chk("gate",      32'(bus.fs_dirty_upd_gate),    32'(m_updt));
        chk("fflags",    32'(bus.rtu_cp0_fflags),       32'(m_ff));
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cyc(input bit a, input bit wv, input logic [1:0] wp,
                       input logic [4:0] wf, input bit r, input bit f);
        bit full_m, byp_hit, hd, ret;
        chk_regs();
        drive(a, wv, wp, wf, r, f);
        #1;
        full_m  = (m_q.size() == DEPTH);
        byp_hit = BYP && wv && (m_q.size() > 0) && (int'(wp) == m_q[0]);
        hd      = (m_q.size() > 0) && (m_done[m_q[0]] || byp_hit);
        ret     = r && hd;
        chk("head_done", 32'(bus.rtu_fp_head_done), 32'(hd));
        m_updt = ret;
        if (ret) m_ff = byp_hit ? wf : m_flags[m_q[0]];
        if (f) begin
            m_q.delete();
            for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
            m_tail = 0;
        end else begin
            if (wv && in_q(int'(wp))) begin
                m_done[wp]  = 1'b1;
                m_flags[wp] = wf;
            end
            if (ret) begin
                m_done[m_q[0]] = 1'b0;
                void'(m_q.pop_front());
            end
            if (a && !full_m) begin
                m_q.push_back(m_tail);
                m_done[m_tail]  = 1'b0;
                m_flags[m_tail] = 5'd0;
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset hits while a retire of a done head is being presented.
    task automatic rst_mid();
        chk_regs();
        drive(1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_full",  32'(bus.rtu_idu_fp_full),      32'd0);
        chk("rst_ptr",   32'(bus.rtu_idu_fp_alloc_ptr), 32'd0);
        chk("rst_hd",    32'(bus.rtu_fp_head_done),     32'd0);
        chk("rst_updt",  32'(bus.rtu_cp0_fflags_updt),  32'd0);
        chk("rst_gate",  32'(bus.fs_dirty_upd_gate),    32'd0);
        chk("rst_ff",    32'(bus.rtu_cp0_fflags),       32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        drive(1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("por_updt", 32'(bus.rtu_cp0_fflags_updt), 32'd0);
        chk("por_ptr",  32'(bus.rtu_idu_fp_alloc_ptr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: single instruction round trip
        cyc(1, 0, 2'd0, 5'd0,     0, 0);
        cyc(0, 1, 2'd0, 5'b00001, 0, 0);
        cyc(0, 0, 2'd0, 5'd0,     1, 0);
        cyc(0, 0, 2'd0, 5'd0,     0, 0);
        cyc(0, 0, 2'd0, 5'd0,     0, 0);

        // 2: fill, then alloc + retire while full
        cyc(0, 0, 2'd0, 5'd0, 0, 1);
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 2'd0, 5'd0, 0, 0);
        cyc(0, 1, 2'd0, 5'b00011, 0, 0);
        cyc(1, 0, 2'd0, 5'd0,     1, 0);
        cyc(0, 0, 2'd0, 5'd0,     0, 0);
        cyc(0, 0, 2'd0, 5'd0,     0, 1);

        // 3: out-of-order writeback, in-order drain
        for (int i = 0; i < 3; i++) cyc(1, 0, 2'd0, 5'd0, 0, 0);
        cyc(0, 1, 2'd2, 5'b10000, 0, 0);
        cyc(0, 1, 2'd0, 5'b00100, 0, 0);
        cyc(0, 1, 2'd1, 5'b01000, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 2'd0, 5'd0, 1, 0);

        // 4: flush with same-cycle retire
        cyc(1, 0, 2'd0, 5'd0,     0, 0);
        cyc(1, 0, 2'd0, 5'd0,     0, 0);
        cyc(0, 1, 2'd0, 5'b00110, 0, 0);
        cyc(0, 0, 2'd0, 5'd0,     1, 1);
        cyc(0, 1, 2'd1, 5'b11111, 0, 0);
        cyc(1, 0, 2'd0, 5'd0,     0, 0);
        cyc(0, 0, 2'd0, 5'd0,     1, 0);

        // 5: retire before writeback; writeback + retire on head
        cyc(0, 0, 2'd0, 5'd0,     1, 0);
        cyc(0, 1, 2'd0, 5'b00010, 1, 0);
        cyc(0, 0, 2'd0, 5'd0,     0, 0);
        cyc(0, 0, 2'd0, 5'd0,     1, 0);
        cyc(0, 0, 2'd0, 5'd0,     0, 0);

        // 6: reset while two entries pending and a retire in flight
        cyc(1, 0, 2'd0, 5'd0,     0, 0);
        cyc(1, 1, 2'd0, 5'b01010, 0, 0);
        cyc(0, 1, 2'd1, 5'b00101, 0, 0);
        rst_mid();
        cyc(0, 0, 2'd0, 5'd0, 0, 0);
        cyc(0, 0, 2'd0, 5'd0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (n == 300) rst_mid();
            cyc($urandom_range(0, 99) < 60,
                1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)),
                5'($urandom()),
                1'($urandom_range(0, 1)),
                $urandom_range(0, 99) < 4);
        end
        cyc(0, 0, 2'd0, 5'd0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
